// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encodings,
// default watchdog limit and state classification helper.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF     = 3'd0,
        ST_ID     = 3'd1,
        ST_MEM    = 3'd2,
        ST_WB     = 3'd3,
        ST_PC     = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int DEFAULT_TIMEOUT = 64;

    // True for the states that do work and are therefore watched and haltable.
    function automatic logic is_busy(input state_e s);
        return (s == ST_IF) || (s == ST_ID) || (s == ST_MEM) ||
               (s == ST_WB) || (s == ST_PC);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller (master) and the
// datapath stages (slave): decoder flags, done strobes and stage enables.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             halt;
    logic             branch;
    logic             regwrite;
    logic             mem_rd;
    logic             mem_wr;
    logic             if_done;
    logic             id_done;
    logic             mem_done;
    logic             wb_done;
    logic             pc_done;
    logic             instrfetch;
    logic             decode;
    logic             mem;
    logic             wb;
    logic             PCwrite;
    logic             halted;
    logic             err;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  halt, branch, regwrite, mem_rd, mem_wr,
        input  if_done, id_done, mem_done, wb_done, pc_done,
        output instrfetch, decode, mem, wb, PCwrite, halted, err,
        output state, retired
    );

    modport slave (
        output halt, branch, regwrite, mem_rd, mem_wr,
        output if_done, id_done, mem_done, wb_done, pc_done,
        input  instrfetch, decode, mem, wb, PCwrite, halted, err,
        input  state, retired
    );
endinterface

// File: rtl/multicycle_ctrl_stage_watchdog.sv
// Per-state stall counter: counts cycles spent in one state and flags
// expiry once the count reaches TIMEOUT-1.
module stage_watchdog
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Saturate at LAST so a stalled-but-not-moving state cannot wrap to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: IF/ID/MEM/WB/PC with Moore stage
// enables, stall watchdog, halt handling and retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int HAS_MEM = 1,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    state_e           state_q;
    state_e           state_d;
    logic             flg_rd_q;
    logic             flg_rw_q;
    logic [CNT_W-1:0] retired_q;
    logic             wd_expire;
    logic             wd_clear;
    logic             wd_en;
    logic             retire;

    assign wd_clear = (state_d != state_q);
    assign wd_en    = is_busy(state_q);

    stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Only mem_rd and regwrite steer a later state (MEM exit), so only those are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flg_rd_q <= 1'b0;
            flg_rw_q <= 1'b0;
        end else if ((state_q == ST_ID) && bus.id_done) begin
            flg_rd_q <= bus.mem_rd;
            flg_rw_q <= bus.regwrite;
        end
    end

    assign retire = (state_q == ST_PC) && bus.pc_done && !bus.halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF: begin
                if (bus.if_done)     state_d = ST_ID;
                else if (wd_expire)  state_d = ST_ERR;
            end
            ST_ID: begin
                if (bus.id_done) begin
                    if ((HAS_MEM != 0) && (bus.mem_rd || bus.mem_wr)) state_d = ST_MEM;
                    else if (bus.branch)                              state_d = ST_PC;
                    else if (bus.regwrite)                            state_d = ST_WB;
                    else                                              state_d = ST_PC;
                end else if (wd_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_MEM: begin
                if (bus.mem_done)    state_d = (flg_rd_q && flg_rw_q) ? ST_WB : ST_PC;
                else if (wd_expire)  state_d = ST_ERR;
            end
            ST_WB: begin
                if (bus.wb_done)     state_d = ST_PC;
                else if (wd_expire)  state_d = ST_ERR;
            end
            ST_PC: begin
                if (bus.pc_done)     state_d = ST_IF;
                else if (wd_expire)  state_d = ST_ERR;
            end
            ST_HALTED: state_d = ST_HALTED;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IF;
        endcase
        // Halt beats both done strobes and watchdog expiry; ERR stays ERR.
        if (bus.halt && is_busy(state_q)) begin
            state_d = ST_HALTED;
        end
    end

    assign bus.instrfetch = (state_q == ST_IF);
    assign bus.decode     = (state_q == ST_ID);
    assign bus.mem        = (state_q == ST_MEM);
    assign bus.wb         = (state_q == ST_WB);
    assign bus.PCwrite    = (state_q == ST_PC);
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.err        = (state_q == ST_ERR);
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction paths, wrap, halt,
// watchdog expiry and asynchronous reset, plus a HAS_MEM=0 instance.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(4))  bus1 ();
    multicycle_ctrl_if #(.CNT_W(32)) bus2 ();

    multicycle_ctrl #(.HAS_MEM(1), .TIMEOUT(4), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    multicycle_ctrl #(.HAS_MEM(0), .TIMEOUT(DEFAULT_TIMEOUT), .CNT_W(32)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        bus1.halt = 0; bus1.branch = 0; bus1.regwrite = 0; bus1.mem_rd = 0; bus1.mem_wr = 0;
        bus1.if_done = 0; bus1.id_done = 0; bus1.mem_done = 0; bus1.wb_done = 0; bus1.pc_done = 0;
        bus2.halt = 0; bus2.branch = 0; bus2.regwrite = 0; bus2.mem_rd = 0; bus2.mem_wr = 0;
        bus2.if_done = 0; bus2.id_done = 0; bus2.mem_done = 0; bus2.wb_done = 0; bus2.pc_done = 0;
    endtask

    task automatic do_branch;
        bus1.if_done = 1; tick; clr_in;
        bus1.id_done = 1; bus1.branch = 1; tick; clr_in;
        bus1.pc_done = 1; tick; clr_in;
    endtask

    task automatic pulse_reset;
        rst_n = 0; tick; rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        clr_in;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", bus1.state, 0);
        check("rst_retired", bus1.retired, 0);
        check("rst_ifetch", bus1.instrfetch, 1);
        check("rst_others", {bus1.decode, bus1.mem, bus1.wb, bus1.PCwrite, bus1.halted, bus1.err}, 0);
        rst_n = 1;

        // HAS_MEM=0: loads/stores bypass MEM
        bus2.if_done = 1; tick; clr_in;
        check("m0_id", bus2.state, 1);
        bus2.id_done = 1; bus2.mem_rd = 1; bus2.regwrite = 1; tick; clr_in;
        check("m0_load_wb", bus2.state, 3);
        bus2.wb_done = 1; tick; clr_in;
        bus2.pc_done = 1; tick; clr_in;
        bus2.if_done = 1; tick; clr_in;
        bus2.id_done = 1; bus2.mem_wr = 1; tick; clr_in;
        check("m0_store_pc", bus2.state, 4);
        bus2.pc_done = 1; tick; clr_in;
        check("m0_retired", bus2.retired, 2);

        pulse_reset;
        check("rerst_state", bus1.state, 0);
        tick;
        check("if_stay", bus1.state, 0);

        // ALU op: IF, ID, WB, PC, IF
        bus1.if_done = 1; tick; clr_in;
        check("alu_id", bus1.state, 1);
        check("alu_decode", bus1.decode, 1);
        bus1.id_done = 1; bus1.regwrite = 1; tick; clr_in;
        check("alu_wb", bus1.state, 3);
        bus1.wb_done = 1; tick; clr_in;
        check("alu_pc", bus1.state, 4);
        check("alu_pcwrite", bus1.PCwrite, 1);
        bus1.pc_done = 1; tick; clr_in;
        check("alu_if", bus1.state, 0);
        check("alu_retired", bus1.retired, 1);

        // Load: ID, MEM, WB, PC
        bus1.if_done = 1; tick; clr_in;
        bus1.id_done = 1; bus1.mem_rd = 1; bus1.regwrite = 1; tick; clr_in;
        check("ld_mem", bus1.state, 2);
        check("ld_mem_en", bus1.mem, 1);
        bus1.mem_done = 1; tick; clr_in;
        check("ld_wb", bus1.state, 3);
        bus1.wb_done = 1; tick; clr_in;
        bus1.pc_done = 1; tick; clr_in;
        check("ld_retired", bus1.retired, 2);

        // Store: ID, MEM, PC
        bus1.if_done = 1; tick; clr_in;
        bus1.id_done = 1; bus1.mem_wr = 1; tick; clr_in;
        check("st_mem", bus1.state, 2);
        bus1.mem_done = 1; tick; clr_in;
        check("st_pc", bus1.state, 4);
        bus1.pc_done = 1; tick; clr_in;
        check("st_retired", bus1.retired, 3);

        // Branch: stray wb_done in ID ignored, then straight to PC
        bus1.if_done = 1; tick; clr_in;
        bus1.wb_done = 1; tick; clr_in;
        check("br_ignore_wb", bus1.state, 1);
        bus1.id_done = 1; bus1.branch = 1; bus1.regwrite = 1; tick; clr_in;
        check("br_pc", bus1.state, 4);
        bus1.pc_done = 1; tick; clr_in;
        check("br_retired", bus1.retired, 4);

        // Counter wrap at CNT_W=4
        for (int i = 0; i < 11; i++) do_branch;
        check("wrap_15", bus1.retired, 15);
        do_branch;
        check("wrap_0", bus1.retired, 0);

        // Halt alongside pc_done
        bus1.if_done = 1; tick; clr_in;
        bus1.id_done = 1; bus1.branch = 1; tick; clr_in;
        bus1.pc_done = 1; bus1.halt = 1; tick; clr_in;
        check("halt_state", bus1.state, 5);
        check("halt_retired", bus1.retired, 0);
        check("halt_pcwrite", bus1.PCwrite, 0);
        bus1.if_done = 1; repeat (3) tick; clr_in;
        check("halt_sticky", bus1.state, 5);
        check("halt_flag", bus1.halted, 1);

        // Asynchronous reset in the middle of MEM
        pulse_reset;
        check("rel_ifetch", bus1.instrfetch, 1);
        bus1.if_done = 1; tick; clr_in;
        bus1.id_done = 1; bus1.mem_rd = 1; tick; clr_in;
        check("ar_mem", bus1.state, 2);
        #2 rst_n = 0;
        #1;
        check("ar_state", bus1.state, 0);
        check("ar_mem_en", bus1.mem, 0);
        @(posedge clk); #1 rst_n = 1;
        check("ar_rel_ifetch", {bus1.instrfetch, bus1.decode, bus1.mem, bus1.wb, bus1.PCwrite}, 5'b10000);

        // Watchdog: ID held 4 cycles then ERR, ERR ignores halt
        bus1.if_done = 1; tick; clr_in;
        repeat (3) tick;
        check("wd_still_id", bus1.state, 1);
        tick;
        check("wd_err", bus1.state, 6);
        bus1.halt = 1; repeat (2) tick; clr_in;
        check("err_sticky", bus1.state, 6);
        check("err_flag", {bus1.err, bus1.halted}, 2'b10);

        // Done strobe on the expiry cycle wins
        pulse_reset;
        bus1.if_done = 1; tick; clr_in;
        repeat (3) tick;
        bus1.id_done = 1; bus1.regwrite = 1; tick; clr_in;
        check("wd_done_wins", bus1.state, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
